// File: rtl/key_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_pkg
// Purpose  : Shared definitions for the front-panel operand entry block.
//            Contents: key index constants, the EDIT/PENDING state type,
//            the signed value limits and a ms-to-clock-cycles helper.
// Revision : 1.0 - initial release
// ============================================================================
package key_entry_pkg;

    // Index of each button within key_n
    localparam int KEY_INC    = 0;
    localparam int KEY_DEC    = 1;
    localparam int KEY_LOAD   = 2;
    localparam int KEY_COMMIT = 3;
    localparam int NUM_KEYS   = 4;

    // Entry states
    typedef enum logic [0:0] {
        EDIT    = 1'b0,
        PENDING = 1'b1
    } entry_state_e;

    // Saturation limits for the signed 8-bit edit value
    localparam logic signed [7:0] VALUE_MAX = 8'sd127;
    localparam logic signed [7:0] VALUE_MIN = -8'sd128;

    // Convert milliseconds to clock cycles.
    // 64-bit intermediate so 500 ms at 50 MHz does not overflow.
    // Never returns 0 so a degenerate configuration still yields a counter.
    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_hz);
        logic [63:0] w_cycles;
        w_cycles = (64'(ms) * 64'(clk_hz)) / 64'd1000;
        if (w_cycles == 64'd0) begin
            w_cycles = 64'd1;
        end
        return 32'(w_cycles);
    endfunction

endpackage : key_entry_pkg
`default_nettype wire

// File: rtl/key_press_filter.sv
`default_nettype none
// ============================================================================
// Module   : key_press_filter
// Purpose  : One push-button conditioner: 2-flop synchroniser, resettable
//            debounce counter and a 1-cycle press pulse on the debounced
//            released->pressed edge. Release produces no pulse.
// Ports    : clk          in  clock, rising edge
//            rst_n        in  synchronous reset, active-low
//            key_n        in  raw button, active-low, asynchronous
//            pressed      out debounced level, 1 = pressed
//            press_pulse  out 1-cycle pulse when the debounced level presses
// Revision : 1.0 - initial release
// ============================================================================
module key_press_filter #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_pressed;
    logic               r_pulse;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_raw_pressed;
    logic w_disagree;
    logic w_toggle;

    assign w_raw_pressed = ~r_sync2;
    assign w_disagree    = w_raw_pressed ^ r_pressed;
    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle
    assign w_toggle      = w_disagree && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchroniser preset to the released (high) level
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_pressed <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_pulse <= w_toggle && !r_pressed;
            if (!w_disagree) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_cnt     <= '0;
                r_pressed <= ~r_pressed;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed     = r_pressed;
    assign press_pulse = r_pulse;

endmodule : key_press_filter
`default_nettype wire

// File: rtl/key_value_entry.sv
`default_nettype none
// ============================================================================
// Module   : key_value_entry
// Purpose  : Front-panel operand entry. Debounces 4 active-low buttons,
//            edits a signed 8-bit value (inc/dec saturating, load from
//            switches) and hands committed values out over valid/ready.
//            Optional feature macro: AUTO_REPEAT_EN (inc/dec auto-repeat).
// Ports    : clk        in  1  clock, rising edge
//            rst_n      in  1  synchronous reset, active-low
//            key_n      in  4  raw buttons, active-low: inc, dec, load, commit
//            sw         in  8  switch value, asynchronous
//            value      out 8  signed current edit value
//            disp_en    out 1  1 in EDIT, blinks at 2 Hz in PENDING
//            out_data   out 8  committed value, stable while out_valid
//            out_valid  out 1  committed value available
//            out_ready  in  1  consumer accepts on out_valid & out_ready
// Revision : 1.0 - initial release
// ============================================================================
module key_value_entry
    import key_entry_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_MS     = 30,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic [7:0] sw,
    output logic [7:0] value,
    output logic       disp_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [0:0] c_ST_EDIT    = EDIT;
    localparam logic [0:0] c_ST_PENDING = PENDING;

    localparam int unsigned c_DEB_CYCLES   = ms_to_cycles(DEBOUNCE_MS, CLK_HZ);
    localparam int unsigned c_BLINK_CYCLES = ms_to_cycles(250, CLK_HZ);
    localparam int          c_BLINK_W      = $clog2(c_BLINK_CYCLES + 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(c_BLINK_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_pulse;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_press_filter #(
                .DEBOUNCE_CYCLES (int'(c_DEB_CYCLES))
            ) u_filter (
                .clk         (clk),
                .rst_n       (rst_n),
                .key_n       (key_n[gi]),
                .pressed     (w_pressed[gi]),
                .press_pulse (w_pulse[gi])
            );
        end
    endgenerate

    // Switch synchroniser
    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    logic [0:0]        r_state;
    logic signed [7:0] r_value;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_disp_en;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    // ------------------------------------------------------------------
    // Auto-repeat generator
    // ------------------------------------------------------------------
    logic w_rep_inc;
    logic w_rep_dec;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned c_DELAY_CYCLES = ms_to_cycles(REPEAT_DELAY_MS, CLK_HZ);
    localparam int unsigned c_RATE_CYCLES  = ms_to_cycles(REPEAT_RATE_MS, CLK_HZ);
    localparam int unsigned c_REP_MAX      = (c_DELAY_CYCLES > c_RATE_CYCLES) ?
                                             c_DELAY_CYCLES : c_RATE_CYCLES;
    localparam int          c_REP_W        = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST = c_REP_W'(c_DELAY_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_RATE_LAST  = c_REP_W'(c_RATE_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic               w_rep_held;
    logic               w_rep_restart;
    logic               w_rep_fire;

    assign w_rep_held    = (r_state == c_ST_EDIT) &&
                           (w_pressed[KEY_INC] || w_pressed[KEY_DEC]);
    // A fresh inc/dec press re-arms the initial delay
    assign w_rep_restart = w_pulse[KEY_INC] || w_pulse[KEY_DEC];
    assign w_rep_fire    = w_rep_held && !w_rep_restart &&
                           (r_rep_first ? (r_rep_cnt == c_DELAY_LAST)
                                        : (r_rep_cnt == c_RATE_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (!w_rep_held || w_rep_restart) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    // Holding both buttons repeats inc only
    assign w_rep_inc = w_rep_fire && w_pressed[KEY_INC];
    assign w_rep_dec = w_rep_fire && !w_pressed[KEY_INC];
`else
    localparam int c_unused_rep_ms = REPEAT_DELAY_MS + REPEAT_RATE_MS;
    assign w_rep_inc = 1'b0;
    assign w_rep_dec = 1'b0;
`endif

    // Debounced levels of load/commit (and inc/dec without repeat) are not needed
    logic w_unused_pressed;
    assign w_unused_pressed = ^w_pressed;

    // ------------------------------------------------------------------
    // Action arbiter: commit > load > inc > dec, EDIT only
    // ------------------------------------------------------------------
    logic w_edit;
    logic w_inc_req;
    logic w_dec_req;
    logic w_do_commit;
    logic w_do_load;
    logic w_do_inc;
    logic w_do_dec;

    assign w_edit      = (r_state == c_ST_EDIT);
    assign w_inc_req   = w_pulse[KEY_INC] || w_rep_inc;
    assign w_dec_req   = w_pulse[KEY_DEC] || w_rep_dec;
    assign w_do_commit = w_edit && w_pulse[KEY_COMMIT];
    assign w_do_load   = w_edit && !w_pulse[KEY_COMMIT] && w_pulse[KEY_LOAD];
    assign w_do_inc    = w_edit && !w_pulse[KEY_COMMIT] && !w_pulse[KEY_LOAD] && w_inc_req;
    assign w_do_dec    = w_edit && !w_pulse[KEY_COMMIT] && !w_pulse[KEY_LOAD] &&
                         !w_inc_req && w_dec_req;

    // Saturating value register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (w_do_load) begin
            r_value <= $signed(r_sw_sync);
        end else if (w_do_inc) begin
            if (r_value != VALUE_MAX) begin
                r_value <= r_value + 8'sd1;
            end
        end else if (w_do_dec) begin
            if (r_value != VALUE_MIN) begin
                r_value <= r_value - 8'sd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM and display blink
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_EDIT;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_disp_en   <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_EDIT: begin
                    r_disp_en   <= 1'b1;
                    r_blink_cnt <= '0;
                    if (w_do_commit) begin
                        r_out_data  <= r_value;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_PENDING;
                    end
                end
                c_ST_PENDING: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_disp_en   <= 1'b1;
                        r_blink_cnt <= '0;
                        r_state     <= c_ST_EDIT;
                    end else if (r_blink_cnt == c_BLINK_LAST) begin
                        r_blink_cnt <= '0;
                        r_disp_en   <= ~r_disp_en;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_EDIT;
                end
            endcase
        end
    end

    assign value     = r_value;
    assign disp_en   = r_disp_en;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule : key_value_entry
`default_nettype wire

// File: tb/tb_key_value_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_value_entry
// Purpose  : Self-checking bench for key_value_entry with scaled timing
//            (CLK_HZ=1000 so 1 ms = 1 cycle). Table-driven edit vectors,
//            hand-written handshake/priority/reset/blink sequences and a
//            randomized run against a clamp-arithmetic reference model.
//            Expected auto-repeat result follows the AUTO_REPEAT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_value_entry;
    import key_entry_pkg::*;

    localparam int CLK_HZ          = 1000;
    localparam int DEBOUNCE_MS     = 3;
    localparam int REPEAT_DELAY_MS = 10;
    localparam int REPEAT_RATE_MS  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [7:0] sw = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] value;
    logic       disp_en;
    logic [7:0] out_data;
    logic       out_valid;

    key_value_entry #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_MS     (DEBOUNCE_MS),
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .sw        (sw),
        .value     (value),
        .disp_en   (disp_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the masked buttons low for 'cycles' cycles, then release and settle
    task automatic press_mask(input logic [3:0] mask, input int cycles);
        @(negedge clk);
        key_n = ~mask;
        tick(cycles);
        key_n = 4'hF;
        tick(10);
    endtask

    task automatic press(input int k, input int cycles);
        logic [3:0] m;
        m = 4'b0000;
        m[k] = 1'b1;
        press_mask(m, cycles);
    endtask

    task automatic load(input logic [7:0] v);
        sw = v;
        press(KEY_LOAD, 6);
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_low", int'(out_valid), 0);
        check("accept_disp_en", int'(disp_en), 1);
        out_ready = 1'b0;
    endtask

    // Reference model: plain clamped integer arithmetic
    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    typedef struct {
        int         op;   // 0 inc, 1 dec, 2 load
        logic [7:0] swv;
        int         exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int m_val;
        int m_out;
        int n;
        int vcnt;
        int exp_rep;

        tbl[0]  = '{2, 8'h7E, 126};
        tbl[1]  = '{0, 8'h00, 127};
        tbl[2]  = '{0, 8'h00, 127};
        tbl[3]  = '{0, 8'h00, 127};
        tbl[4]  = '{2, 8'h81, -127};
        tbl[5]  = '{1, 8'h00, -128};
        tbl[6]  = '{1, 8'h00, -128};
        tbl[7]  = '{2, 8'h00, 0};
        tbl[8]  = '{1, 8'h00, -1};
        tbl[9]  = '{0, 8'h00, 0};
        tbl[10] = '{2, 8'h80, -128};
        tbl[11] = '{0, 8'h00, -127};

        // ---------------- reset state ----------------
        tick(3);
        check("reset_value", int'($signed(value)), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_disp_en", int'(disp_en), 1);
        rst_n = 1'b1;
        tick(2);

        // ---------------- glitch / debounce ----------------
        press(KEY_INC, 2);
        check("glitch_ignored", int'($signed(value)), 0);
        press(KEY_INC, 10);
        check("debounced_inc_once", int'($signed(value)), 1);

        // ---------------- table-driven edit vectors ----------------
        for (int i = 0; i < 12; i++) begin
            case (tbl[i].op)
                0: press(KEY_INC, 6);
                1: press(KEY_DEC, 6);
                default: load(tbl[i].swv);
            endcase
            check($sformatf("vec%0d_value", i), int'($signed(value)), tbl[i].exp);
        end

        // ---------------- handshake ----------------
        load(8'hFB);
        check("hs_loaded", int'($signed(value)), -5);
        out_ready = 1'b0;
        press(KEY_COMMIT, 6);
        check("hs_out_valid", int'(out_valid), 1);
        check("hs_out_data", int'(out_data), 8'hFB);
        press(KEY_INC, 6);
        check("hs_frozen_value", int'($signed(value)), -5);
        check("hs_still_valid", int'(out_valid), 1);
        accept();

        // ---------------- blink period in PENDING ----------------
        @(negedge clk);
        key_n[KEY_COMMIT] = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        key_n = 4'hF;
        check("blink_commit_seen", int'(out_valid), 1);
        check("blink_start_on", int'(disp_en), 1);
        n = 0;
        while (disp_en && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("blink_on_time", n, 250);
        n = 0;
        while (!disp_en && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("blink_off_time", n, 250);
        accept();

        // ---------------- ready already high at commit ----------------
        out_ready = 1'b1;
        @(negedge clk);
        key_n[KEY_COMMIT] = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        key_n = 4'hF;
        tick(10);
        out_ready = 1'b0;
        check("ready_high_valid_cycles", vcnt, 1);
        check("ready_high_out_data", int'(out_data), 8'hFB);

        // ---------------- priority: commit beats inc ----------------
        load(8'h03);
        press_mask(4'b1001, 6);
        check("prio_out_data", int'(out_data), 3);
        check("prio_value", int'($signed(value)), 3);
        check("prio_valid", int'(out_valid), 1);
        accept();

        // ---------------- reset mid-operation ----------------
        load(8'h11);
        press(KEY_COMMIT, 6);
        check("rst_pre_valid", int'(out_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_value", int'($signed(value)), 0);
        check("rst_mid_disp_en", int'(disp_en), 1);
        check("rst_mid_out_data", int'(out_data), 0);
        tick(2);
        load(8'h22);
        press(KEY_COMMIT, 6);
        check("rst_next_valid", int'(out_valid), 1);
        check("rst_next_data", int'(out_data), 8'h22);
        accept();

        // ---------------- randomized against reference model ----------------
        load(8'h00);
        m_val = 0;
        m_out = 8'h22;
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    press(KEY_INC, int'($urandom_range(4, 8)));
                    m_val = clamp(m_val + 1);
                end
                1: begin
                    press(KEY_DEC, int'($urandom_range(4, 8)));
                    m_val = clamp(m_val - 1);
                end
                2: begin
                    sw = 8'($urandom);
                    press(KEY_LOAD, 6);
                    m_val = int'($signed(sw));
                end
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    press(KEY_COMMIT, 6);
                    m_out = m_val & 8'hFF;
                    check($sformatf("rnd%0d_valid", it), int'(out_valid), out_ready ? 0 : 1);
                    out_ready = 1'b1;
                    tick(2);
                    out_ready = 1'b0;
                end
            endcase
            check($sformatf("rnd%0d_value", it), int'($signed(value)), m_val);
            check($sformatf("rnd%0d_out_data", it), int'(out_data), m_out);
        end

        // ---------------- long hold (auto-repeat when enabled) ----------------
        load(8'h00);
`ifdef AUTO_REPEAT_EN
        exp_rep = 6;
`else
        exp_rep = 1;
`endif
        press(KEY_INC, 30);
        check("hold_inc_value", int'($signed(value)), exp_rep);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_value_entry
`default_nettype wire
